// File: rtl/lal_count_cmp_unit.sv
// Loadable up/down counter (wrap or saturate) with a ge threshold flag, plus a gated field
// comparator whose registered mismatch drives a saturating error counter; single clock, sync reset.
module lal_count_cmp_unit #(
  parameter int CNT_W    = 9,
  parameter int CMP_W    = 4,
  parameter bit SAT_MODE = 1'b0,
  parameter int ERR_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             cmp_dis_i,
  input  logic [CMP_W-1:0] fa_i,
  input  logic [CMP_W-1:0] fb_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o,
  output logic             ge_o,
  output logic             wrap_p_o,
  output logic             mis_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             sat_seen_q, sat_seen_d;
  logic             ge_q, ge_d;
  logic             mis_q, mis_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             at_limit;

  // The limit being approached depends on the direction sampled on this same edge.
  assign at_limit = dir_i ? (cnt_q == CNT_MAX) : (cnt_q == '0);

  always_comb begin
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    sat_seen_d = sat_seen_q;
    if (clr_i) begin
      cnt_d      = '0;
      sat_seen_d = 1'b0;
    end else if (hold_i) begin
      cnt_d = cnt_q;
    end else if (load_i) begin
      cnt_d      = load_val_i;
      sat_seen_d = 1'b0;
    end else if (en_i && at_limit) begin
      if (SAT_MODE) begin
        // Pulse only on the first blocked cycle of a saturation run.
        wrap_d     = ~sat_seen_q;
        sat_seen_d = 1'b1;
      end else begin
        cnt_d      = dir_i ? '0 : CNT_MAX;
        wrap_d     = 1'b1;
        sat_seen_d = 1'b0;
      end
    end else if (en_i) begin
      cnt_d      = dir_i ? (cnt_q + CNT_ONE) : (cnt_q - CNT_ONE);
      sat_seen_d = 1'b0;
    end
  end

  always_comb begin
    ge_d  = (cnt_d >= thresh_i);
    mis_d = ~cmp_dis_i && (fa_i != fb_i);
    err_d = err_q;
    if (mis_q && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      sat_seen_q <= 1'b0;
      ge_q       <= 1'b0;
      mis_q      <= 1'b0;
      err_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      sat_seen_q <= sat_seen_d;
      ge_q       <= ge_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign tc_o      = dir_i ? (cnt_q == CNT_MAX) : (cnt_q == '0);
  assign ge_o      = ge_q;
  assign wrap_p_o  = wrap_q;
  assign mis_o     = mis_q;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_lal_count_cmp_unit.sv
// Directed bench: a wrapping instance and a saturating instance share all inputs;
// expected values are hand-computed constants checked one cycle at a time.
module tb_lal_count_cmp_unit;

  logic       clk_i = 1'b0;
  logic       rst_i, clr_i, hold_i, load_i, en_i, dir_i, cmp_dis_i;
  logic [8:0] load_val_i, thresh_i;
  logic [3:0] fa_i, fb_i;

  logic [8:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, ge_w, ge_s, wrap_w, wrap_s, mis_w, mis_s;
  logic [3:0] err_w, err_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  lal_count_cmp_unit #(.CNT_W(9), .CMP_W(4), .SAT_MODE(1'b0), .ERR_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .hold_i(hold_i), .load_i(load_i),
    .load_val_i(load_val_i), .en_i(en_i), .dir_i(dir_i), .cmp_dis_i(cmp_dis_i),
    .fa_i(fa_i), .fb_i(fb_i), .thresh_i(thresh_i),
    .cnt_o(cnt_w), .tc_o(tc_w), .ge_o(ge_w), .wrap_p_o(wrap_w), .mis_o(mis_w), .err_cnt_o(err_w)
  );

  lal_count_cmp_unit #(.CNT_W(9), .CMP_W(4), .SAT_MODE(1'b1), .ERR_W(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .hold_i(hold_i), .load_i(load_i),
    .load_val_i(load_val_i), .en_i(en_i), .dir_i(dir_i), .cmp_dis_i(cmp_dis_i),
    .fa_i(fa_i), .fb_i(fb_i), .thresh_i(thresh_i),
    .cnt_o(cnt_s), .tc_o(tc_s), .ge_o(ge_s), .wrap_p_o(wrap_s), .mis_o(mis_s), .err_cnt_o(err_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    clr_i = 0; hold_i = 0; load_i = 0; en_i = 0; dir_i = 0;
    load_val_i = '0; thresh_i = '0; fa_i = '0; fb_i = '0; cmp_dis_i = 1;
  endtask

  initial begin
    // Reset with random functional inputs
    rst_i = 1;
    for (int i = 0; i < 2; i++) begin
      clr_i = 1'($urandom); hold_i = 1'($urandom); load_i = 1'($urandom);
      en_i = 1'($urandom); dir_i = 1'($urandom); cmp_dis_i = 1'($urandom);
      load_val_i = 9'($urandom); thresh_i = 9'($urandom);
      fa_i = 4'($urandom); fb_i = 4'($urandom);
      step();
    end
    check("rst_cnt", 32'(cnt_w), 0);
    check("rst_ge", 32'(ge_w), 0);
    check("rst_wrap", 32'(wrap_w), 0);
    check("rst_mis", 32'(mis_w), 0);
    check("rst_err", 32'(err_w), 0);
    check("rst_cnt_sat", 32'(cnt_s), 0);
    check("rst_err_sat", 32'(err_s), 0);

    // Wrap at all-ones counting up
    rst_i = 0; idle_inputs();
    load_i = 1; load_val_i = 9'h1FE; dir_i = 1;
    step();
    check("wrap_load", 32'(cnt_w), 9'h1FE);
    check("wrap_tc0", 32'(tc_w), 0);
    load_i = 0; en_i = 1;
    step();
    check("wrap_c1", 32'(cnt_w), 9'h1FF);
    check("wrap_p1", 32'(wrap_w), 0);
    check("wrap_tc1", 32'(tc_w), 1);
    step();
    check("wrap_c2", 32'(cnt_w), 9'h000);
    check("wrap_p2", 32'(wrap_w), 1);
    check("wrap_tc2", 32'(tc_w), 0);
    step();
    check("wrap_c3", 32'(cnt_w), 9'h001);
    check("wrap_p3", 32'(wrap_w), 0);

    // Saturate at zero counting down; wrapping instance underflows alongside
    idle_inputs();
    load_i = 1; load_val_i = 9'h001;
    step();
    check("sat_load", 32'(cnt_s), 1);
    load_i = 0; en_i = 1; dir_i = 0;
    step();
    check("sat_c1", 32'(cnt_s), 0);
    check("sat_p1", 32'(wrap_s), 0);
    check("sat_tc1", 32'(tc_s), 1);
    step();
    check("sat_c2", 32'(cnt_s), 0);
    check("sat_p2", 32'(wrap_s), 1);
    check("unf_cnt", 32'(cnt_w), 9'h1FF);
    check("unf_wrap", 32'(wrap_w), 1);
    step();
    check("sat_c3", 32'(cnt_s), 0);
    check("sat_p3", 32'(wrap_s), 0);
    step();
    check("sat_c4", 32'(cnt_s), 0);
    check("sat_p4", 32'(wrap_s), 0);

    // Priority clr > hold > load
    idle_inputs();
    clr_i = 1; hold_i = 1; load_i = 1; load_val_i = 9'h0AA; en_i = 1; dir_i = 1;
    step();
    check("pri_clr", 32'(cnt_w), 0);
    check("pri_clr_wrap", 32'(wrap_w), 0);
    clr_i = 0;
    step();
    check("pri_hold", 32'(cnt_w), 0);
    hold_i = 0;
    step();
    check("pri_load", 32'(cnt_w), 9'h0AA);

    // ge tracks the new count on the same cycle
    idle_inputs();
    thresh_i = 9'h010; load_i = 1; load_val_i = 9'h00E;
    step();
    check("ge_0E", 32'(ge_w), 0);
    load_i = 0; en_i = 1; dir_i = 1;
    step();
    check("ge_cnt0F", 32'(cnt_w), 9'h00F);
    check("ge_0F", 32'(ge_w), 0);
    step();
    check("ge_cnt10", 32'(cnt_w), 9'h010);
    check("ge_10", 32'(ge_w), 1);
    step();
    check("ge_11", 32'(ge_w), 1);

    // Mismatch flag and saturating error counter
    idle_inputs();
    fa_i = 4'h5; fb_i = 4'h7; cmp_dis_i = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        check("mis_first", 32'(mis_w), 1);
        check("err_first", 32'(err_w), 0);
      end
      if (k == 2) check("err_second", 32'(err_w), 1);
      if (k == 16) check("err_reach15", 32'(err_w), 15);
    end
    check("err_hold15", 32'(err_w), 15);
    check("err_hold15_sat", 32'(err_s), 15);
    cmp_dis_i = 1;
    step();
    check("mis_dis", 32'(mis_w), 0);
    check("err_after_dis", 32'(err_w), 15);
    clr_i = 1;
    step();
    check("clr_keeps_err", 32'(err_w), 15);
    check("clr_cnt", 32'(cnt_w), 0);

    // Load all-ones with en=1: loads without wrap
    idle_inputs();
    load_i = 1; load_val_i = 9'h1FF; en_i = 1; dir_i = 1;
    step();
    check("ld1ff_cnt", 32'(cnt_w), 9'h1FF);
    check("ld1ff_wrap", 32'(wrap_w), 0);

    // Reset mid-count, then resume
    load_i = 0; rst_i = 1;
    step();
    check("midrst_cnt", 32'(cnt_w), 0);
    check("midrst_err", 32'(err_w), 0);
    rst_i = 0;
    step();
    check("resume_cnt", 32'(cnt_w), 1);

    // Direction change takes effect on the same edge
    dir_i = 0;
    step();
    check("dir_down", 32'(cnt_w), 0);
    dir_i = 1;
    step();
    check("dir_up", 32'(cnt_w), 1);

    // Hold blocks counting
    hold_i = 1;
    step();
    check("hold_cnt", 32'(cnt_w), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
